// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris piece generation path.
package tetris_pkg;

   typedef enum logic [2:0] {
      I = 3'd0,
      O = 3'd1,
      T = 3'd2,
      S = 3'd3,
      Z = 3'd4,
      J = 3'd5,
      L = 3'd6
   } shape_t;

   typedef logic [1:0] rot_t;

   typedef struct packed {
      shape_t shape;
      rot_t   rot;
   } piece_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_READY
   } sched_state_t;

   localparam int unsigned NUM_SHAPES = 7;
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;

   // (a + b) mod 7 for small operands (a, b <= 7)
   function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= 4'd7) sum = sum - 4'd7;
      if (sum >= 4'd7) sum = sum - 4'd7;
      return sum[2:0];
   endfunction

endpackage

// File: rtl/bag_picker.sv
// Combinational 7-bag draw: picks the first unused shape at or after the
// start index (wrapping mod 7) and returns the updated bag mask, which
// empties itself once the last shape of the bag is taken.
module bag_picker
   import tetris_pkg::*;
(
   input  logic [NUM_SHAPES-1:0] i_bag_used,
   input  logic [2:0]            i_s0,
   output shape_t                o_shape,
   output logic [NUM_SHAPES-1:0] o_bag_used_nxt
);

   logic                  w_found;
   logic [2:0]            w_idx;
   logic [NUM_SHAPES-1:0] w_set;

   // scan from i_s0 upward for the first shape still in the bag
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NUM_SHAPES; k++) begin
         if (!w_found && !i_bag_used[mod7_add(i_s0, 3'(k))]) begin
            w_found = 1'b1;
            w_idx   = mod7_add(i_s0, 3'(k));
         end
      end
   end

   // mark the pick; a full bag wraps straight back to empty
   always_comb begin
      w_set          = i_bag_used | (NUM_SHAPES'(1) << w_idx);
      o_bag_used_nxt = (&w_set) ? '0 : w_set;
      o_shape        = shape_t'(w_idx);
   end

endmodule

// File: rtl/piece_scheduler.sv
// Piece order generator: free-running LFSR feeding a 7-bag picker, with a
// head + DEPTH preview queue handed out one piece per next_req.
module piece_scheduler
   import tetris_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter logic [15:0] SEED  = 16'hACE1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               next_req,
   output logic               piece_valid,
   output logic [2:0]         piece_shape,
   output logic [1:0]         piece_rot,
   output logic [3*DEPTH-1:0] preview_shape,
   output logic [2:0]         bag_left
);

   sched_state_t          r_state;
   sched_state_t          w_state_nxt;
   logic [15:0]           r_lfsr;
   logic [2:0]            r_count;
   logic [NUM_SHAPES-1:0] r_bag_used;
   piece_t                r_queue [DEPTH+1];

   logic                  w_clear;
   logic                  w_append;
   logic                  w_pop;
   logic [2:0]            w_s0;
   shape_t                w_pick_shape;
   logic [NUM_SHAPES-1:0] w_bag_nxt;
   piece_t                w_new;

   assign w_s0  = (r_lfsr[2:0] == 3'd7) ? 3'd0 : r_lfsr[2:0];
   assign w_new = '{shape: w_pick_shape, rot: r_lfsr[4:3]};

   bag_picker u_bag_picker (
      .i_bag_used     (r_bag_used),
      .i_s0           (w_s0),
      .o_shape        (w_pick_shape),
      .o_bag_used_nxt (w_bag_nxt)
   );

   // LFSR advances every cycle regardless of state; only reset reseeds it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_lfsr <= SEED;
      else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state and per-cycle queue actions; start overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_append    = 1'b0;
      w_pop       = 1'b0;
      if (start) begin
         w_clear     = 1'b1;
         w_state_nxt = ST_FILL;
      end else begin
         case (r_state)
            ST_FILL: begin
               w_append = 1'b1;
               if (r_count == 3'(DEPTH)) w_state_nxt = ST_READY;
            end
            ST_READY: w_pop = next_req;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // queue, fill count and bag mask
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i <= DEPTH; i++) r_queue[i] <= '0;
         r_count    <= '0;
         r_bag_used <= '0;
      end else if (w_clear) begin
         for (int unsigned i = 0; i <= DEPTH; i++) r_queue[i] <= '0;
         r_count    <= '0;
         r_bag_used <= '0;
      end else if (w_append) begin
         for (int unsigned i = 0; i <= DEPTH; i++) begin
            if (r_count == 3'(i)) r_queue[i] <= w_new;
         end
         r_count    <= r_count + 3'd1;
         r_bag_used <= w_bag_nxt;
      end else if (w_pop) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_queue[i] <= r_queue[i+1];
         r_queue[DEPTH] <= w_new;
         r_bag_used     <= w_bag_nxt;
      end
   end

   // output mapping straight from registered state
   always_comb begin
      piece_valid   = (r_state == ST_READY);
      piece_shape   = r_queue[0].shape;
      piece_rot     = r_queue[0].rot;
      bag_left      = 3'(NUM_SHAPES) - 3'($countones(r_bag_used));
      preview_shape = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         preview_shape[3*k +: 3] = r_queue[k+1].shape;
      end
   end

endmodule

// File: tb/tb_piece_scheduler.sv
// Randomized bench for piece_scheduler against a queue-based reference model,
// plus an exhaustive check of the bag_picker draw rule.
module tb_piece_scheduler;

   localparam int DEPTH = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               next_req = 1'b0;
   logic               piece_valid;
   logic [2:0]         piece_shape;
   logic [1:0]         piece_rot;
   logic [3*DEPTH-1:0] preview_shape;
   logic [2:0]         bag_left;

   logic [6:0] bp_used;
   logic [2:0] bp_s0;
   logic [2:0] bp_shape;
   logic [6:0] bp_nxt;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   piece_scheduler #(.DEPTH(DEPTH), .SEED(SEED)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .next_req      (next_req),
      .piece_valid   (piece_valid),
      .piece_shape   (piece_shape),
      .piece_rot     (piece_rot),
      .preview_shape (preview_shape),
      .bag_left      (bag_left)
   );

   bag_picker u_bp (
      .i_bag_used     (bp_used),
      .i_s0           (bp_s0),
      .o_shape        (bp_shape),
      .o_bag_used_nxt (bp_nxt)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit [15:0] m_lfsr;
   bit [6:0]  m_used;
   bit        m_active;
   int        m_qs[$];
   int        m_qr[$];
   int        popped[$];

   task automatic model_reset();
      m_lfsr = SEED; m_used = '0; m_active = 1'b0;
      m_qs.delete(); m_qr.delete(); popped.delete();
   endtask

   task automatic model_draw(output int sh, output int rot);
      int s0;
      s0 = int'(m_lfsr) % 8;
      if (s0 == 7) s0 = 0;
      sh = -1;
      for (int d = 0; d < 7; d++) begin
         if (sh < 0 && !m_used[(s0 + d) % 7]) sh = (s0 + d) % 7;
      end
      rot = (int'(m_lfsr) / 8) % 4;
      m_used[sh] = 1'b1;
      if (m_used == 7'h7F) m_used = '0;
   endtask

   task automatic model_edge(input bit st, input bit nr);
      int sh, rot;
      if (st) begin
         m_qs.delete(); m_qr.delete(); m_used = '0; m_active = 1'b1;
      end else if (m_active && m_qs.size() < DEPTH + 1) begin
         model_draw(sh, rot); m_qs.push_back(sh); m_qr.push_back(rot);
      end else if (m_qs.size() == DEPTH + 1 && nr) begin
         void'(m_qs.pop_front()); void'(m_qr.pop_front());
         model_draw(sh, rot); m_qs.push_back(sh); m_qr.push_back(rot);
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   endtask

   task automatic compare_all();
      check_val("valid", int'(piece_valid), (m_qs.size() == DEPTH + 1) ? 1 : 0);
      check_val("shape", int'(piece_shape), (m_qs.size() > 0) ? m_qs[0] : 0);
      check_val("rot", int'(piece_rot), (m_qr.size() > 0) ? m_qr[0] : 0);
      for (int k = 0; k < DEPTH; k++)
         check_val($sformatf("preview%0d", k), int'(preview_shape[3*k +: 3]),
                   (m_qs.size() > k + 1) ? m_qs[k+1] : 0);
      check_val("bag_left", int'(bag_left), 7 - $countones(m_used));
   endtask

   // one clock: drive inputs, update model at the edge, compare 1 time unit later
   task automatic step(input bit st, input bit nr);
      bit   pre_valid;
      int   pre_head;
      bit [6:0] mask;
      start = st; next_req = nr;
      pre_valid = piece_valid; pre_head = int'(piece_shape);
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge(st, nr);
      #1;
      compare_all();
      if (!reset && st) popped.delete();
      if (!reset && !st && pre_valid && nr) begin
         popped.push_back(pre_head);
         if (popped.size() % 7 == 0) begin
            mask = '0;
            for (int i = popped.size() - 7; i < popped.size(); i++) mask[popped[i]] = 1'b1;
            check_val("bag_perm", int'(mask), 127);
         end
      end
   endtask

   task automatic apply_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      #2;
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int exp_cycles);
      int n;
      n = 0;
      while (!piece_valid && n < 20) begin
         step(1'b0, 1'b0);
         n++;
      end
      check_val("valid_latency", n, exp_cycles);
   endtask

   int seq_buf[14];
   int seq_ref[14];

   task automatic run_seq(input int off);
      apply_reset();
      for (int i = 0; i < off; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      wait_valid(DEPTH + 1);
      for (int i = 0; i < 14; i++) begin
         seq_buf[i] = int'(piece_shape);
         step(1'b0, 1'b1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // bag_picker draw rule, every reachable mask and start index
      for (int u = 0; u < 127; u++) begin
         for (int s = 0; s < 7; s++) begin
            int exp_sh;
            bit [6:0] exp_used;
            exp_sh = -1;
            for (int d = 0; d < 7; d++)
               if (exp_sh < 0 && !u[(s + d) % 7]) exp_sh = (s + d) % 7;
            exp_used = 7'(u) | (7'd1 << exp_sh);
            if (exp_used == 7'h7F) exp_used = '0;
            bp_used = 7'(u); bp_s0 = 3'(s);
            #1;
            check_val("pick_shape", int'(bp_shape), exp_sh);
            check_val("pick_used", int'(bp_nxt), int'(exp_used));
         end
      end
      bp_used = 7'b1011111; bp_s0 = 3'd0;
      #1;
      check_val("last_in_bag_shape", int'(bp_shape), 5);
      check_val("last_in_bag_clear", int'(bp_nxt), 0);

      // reset, then next_req with no start: nothing moves
      apply_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
      check_val("idle_valid", int'(piece_valid), 0);
      check_val("idle_bag_left", int'(bag_left), 7);

      // start -> valid DEPTH+2 cycles after the start edge
      step(1'b1, 1'b0);
      wait_valid(DEPTH + 1);

      // continuous consumption across many bag boundaries
      for (int i = 0; i < 70; i++) step(1'b0, 1'b1);
      check_val("held_valid", int'(piece_valid), 1);

      // start together with next_req: restart, no pop
      step(1'b1, 1'b1);
      check_val("restart_valid", int'(piece_valid), 0);
      check_val("restart_bag_left", int'(bag_left), 7);
      wait_valid(DEPTH + 1);

      // randomized traffic including restarts and resets
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) apply_reset();
         else if (r < 6) step(1'b1, 1'($urandom_range(0, 1)));
         else if (r < 60) step(1'b0, 1'b1);
         else step(1'b0, 1'($urandom_range(0, 1)));
      end

      // reproducibility: reset mid-fill, then same start offset as reference
      run_seq(5);
      seq_ref = seq_buf;
      apply_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      run_seq(5);
      for (int i = 0; i < 14; i++)
         check_val($sformatf("repro%0d", i), seq_buf[i], seq_ref[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/piece_scheduler.md
# piece_scheduler

Sequences Tetris piece generation for the game controller. Holds a 16-bit LFSR and a 7-bag randomizer, fills a preview queue with (shape, rotation) pairs, and hands out one piece per `next_req` pulse. Sits between the random source and the game-play FSM. It is the only block that decides piece order; each bag of seven pieces is a permutation of all shapes.

## Interface
- `DEPTH`, 3: preview entries behind the current piece; legal range 1..4.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: soft restart; empties the queue, clears the bag and refills.
- `next_req`  in  1: consume the current piece. Honoured only when `piece_valid`=1.
- `piece_valid`  out  1: the current piece and all previews are valid.
- `piece_shape`  out  3: current shape, 0..6.
- `piece_rot`  out  2: current rotation, 0..3.
- `preview_shape`  out  3*DEPTH: previews; entry k is at bits [3k+2:3k], k=0 is the next piece.
- `bag_left`  out  3: number of shapes not yet drawn from the current bag, 1..7.

## Operation
**LFSR**
- 16-bit Galois LFSR with taps mask 16'hB400.
- Advances every cycle in every state. Loaded with `SEED` on reset; not reloaded by `start`.

**Draw (combinational pick, registered result)**
- Start index: `s0 = lfsr[2:0]`; if the value is 7, use 0.
- Shape: the first index s in s0, s0+1, … (mod 7) whose bit in `bag_used` is clear.
- Rotation: `lfsr[4:3]`.
- Set the chosen bit in `bag_used`. If all 7 bits would then be set, clear `bag_used` to 0 instead.
- `bag_left` = 7 − popcount(`bag_used`).

**Queue**
- DEPTH+1 entries. Entry 0 drives `piece_shape`/`piece_rot`; entries 1..DEPTH drive `preview_shape`.

**FSM states**
- IDLE: no draws; `piece_valid`=0. Goes to FILL on `start`.
- FILL: one draw per cycle, appended at the tail. Goes to READY when the count reaches DEPTH+1.
- READY: `piece_valid`=1. On `next_req`, shift all entries toward the head and draw a new tail entry in the same cycle. The queue stays full and `piece_valid` stays 1.

**Priorities and ignored inputs**
- `start` in any state: clear the queue, `bag_used` and `piece_valid`, then go to FILL. `start` beats a simultaneous `next_req`, which is dropped.
- `next_req` in IDLE or FILL is ignored. It is not queued.

**Reset values**
- State IDLE, `bag_used`=0, queue cleared.
- All outputs 0 except `bag_left`=7.

## Timing
- `start` sampled at edge t: FILL from t+1, draws on cycles t+1..t+DEPTH+1, `piece_valid`=1 from cycle t+DEPTH+2.
- `next_req` sampled at edge t in READY: the new head (the old `preview_shape` entry 0) is visible after edge t. Throughput is one piece per cycle with `next_req` held high.
- `bag_used` clears on the same edge that commits the 7th draw of a bag. A bag boundary never stalls the queue.
- Reset mid-FILL or mid-READY: outputs drop to their reset values immediately, with no clock edge needed. The LFSR reseeds, so the sequence after the next `start` is reproducible for the same cycle offset.

## Structure
- Shared package `tetris_pkg`:
  - `shape_t` enum, 3 bits: I, O, T, S, Z, J, L = 0..6
  - `rot_t`, 2 bits
  - `NUM_SHAPES` = 7
  - `LFSR_TAPS` = 16'hB400
- Sub-module `bag_picker`: purely combinational. Inputs are `bag_used` and `s0`; outputs are the chosen shape and the next `bag_used`.
- The LFSR, queue and FSM stay in `piece_scheduler`.

## Test plan
1. Reset, then 10 cycles with `next_req`=1 and no `start` → `piece_valid`=0, shape/rot/previews 0, `bag_left`=7 throughout.
2. DEPTH=3, `start` at t → `piece_valid` rises at t+5. The first 7 pieces obtained via 3 `next_req` pulses (head, previews, new tails) are a permutation of 0..6.
3. `next_req` held for 70 cycles in READY → `piece_valid` stays 1. Each new head equals the prior `preview_shape[2:0]`. Every 7-aligned group is a permutation, and `bag_left` counts 7,6,…,1 then returns to 7.
4. `start` and `next_req` asserted together in READY → no pop. `piece_valid`=0 the next cycle and high again 4 cycles later; `bag_left`=7 after the restart.
5. Force `bag_used`=7'b1011111 with `s0`=0 → picks shape 5, `bag_used` clears to 0, `bag_left`=7.
6. Reset asserted mid-FILL, then `start` at the same cycle offset as a reference run → identical 14-piece sequence, with outputs zero during reset.
